// File: rtl/glacial_core.sv
// glacial_core: byte-serial microcoded engine that interprets RV32I.
// All architectural RISC-V state lives in an external byte-wide synchronous
// SRAM. The engine runs one 16-bit microinstruction every four clocks:
// two fetch phases, one decode phase and one execute phase.
// Optional feature macro: GLACIAL_UART_EN. When it is defined, OUT drives
// uart_tx from ac[0]. When it is undefined, uart_tx is held high and OUT
// does nothing.
module glacial_core #(
  parameter logic [10:0] RESET_PC = 11'h080
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  input  logic        xint,
  input  logic        xtick,
  output logic        uart_tx
);

  typedef enum logic [1:0] {
    PH_FETCH_LO = 2'd0,
    PH_FETCH_HI = 2'd1,
    PH_DECODE   = 2'd2,
    PH_EXEC     = 2'd3
  } phase_t;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_ADC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_JI   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_JT   = 4'hA;
  localparam logic [3:0] OP_MISC = 4'hB;

  localparam logic [3:0] MISC_TAX  = 4'h0;
  localparam logic [3:0] MISC_TXA  = 4'h1;
  localparam logic [3:0] MISC_TAYL = 4'h2;
  localparam logic [3:0] MISC_TAYH = 4'h3;
  localparam logic [3:0] MISC_CLC  = 4'h4;
  localparam logic [3:0] MISC_SEC  = 4'h5;
  localparam logic [3:0] MISC_RORC = 4'h6;
  localparam logic [3:0] MISC_OUT  = 4'h7;
  localparam logic [3:0] MISC_INX  = 4'h8;

  phase_t      phase_q, phase_d;
  logic [10:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  ac_q, ac_d;
  logic        cy_q, cy_d;
  logic [7:0]  x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        ldpend_q, ldpend_d;
`ifdef GLACIAL_UART_EN
  logic        uart_q, uart_d;
`endif

  logic [15:0] addr_c;
  logic        rd_en_c;
  logic        wr_en_c;
  logic [3:0]  op;
  logic [8:0]  alu_res;
  logic [8:0]  ror_res;

  // Full 9-bit add so the carry out lands in bit 8.
  function automatic logic [8:0] add_with_carry(input logic [7:0] a,
                                                input logic [7:0] b,
                                                input logic       c);
    return {1'b0, a} + {1'b0, b} + {8'h00, c};
  endfunction

  // Rotate right through carry: result is {new_ac, new_cy}.
  function automatic logic [8:0] rotate_right_carry(input logic [7:0] a,
                                                    input logic       c);
    return {c, a};
  endfunction

  // Effective address for memory operands. Mode 01 wraps inside page zero,
  // modes 10/11 wrap across the full 16-bit space.
  function automatic logic [15:0] effective_addr(input logic [1:0]  mode,
                                                 input logic [7:0]  imm,
                                                 input logic [7:0]  xr,
                                                 input logic [15:0] yr);
    logic [7:0] zp;
    zp = imm + xr;
    case (mode)
      2'b00:   return {8'h00, imm};
      2'b01:   return {8'h00, zp};
      2'b10:   return yr + {8'h00, imm};
      default: return yr + {8'h00, xr};
    endcase
  endfunction

  // Opcodes whose memory operand is requested in execute and consumed
  // one cycle later, in the next fetch phase 0.
  function automatic logic is_load_op(input logic [3:0] opc);
    return (opc == OP_LD) || (opc == OP_ADC) || (opc == OP_AND) ||
           (opc == OP_OR) || (opc == OP_XOR);
  endfunction

  // Retire a pending load: returns {cy, ac} after combining with m.
  function automatic logic [8:0] load_result(input logic [3:0] opc,
                                             input logic [7:0] a,
                                             input logic       c,
                                             input logic [7:0] m);
    case (opc)
      OP_LD:   return {c, m};
      OP_ADC:  return add_with_carry(a, m, c);
      OP_AND:  return {c, a & m};
      OP_OR:   return {c, a | m};
      OP_XOR:  return {c, a ^ m};
      default: return {c, a};
    endcase
  endfunction

  // ir still holds the previous microinstruction during phase 0, so the
  // pending-load opcode comes straight from it; no separate latch is needed.
  assign op      = ir_q[15:12];
  assign alu_res = load_result(op, ac_q, cy_q, mem_rd_data);
  assign ror_res = rotate_right_carry(ac_q, cy_q);

  // Phase sequencing, fetch, decode and execute next-state logic.
  always_comb begin
    phase_d  = phase_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ac_d     = ac_q;
    cy_d     = cy_q;
    x_d      = x_q;
    y_d      = y_q;
    ldpend_d = ldpend_q;
`ifdef GLACIAL_UART_EN
    uart_d   = uart_q;
`endif
    addr_c   = {4'b0, pc_q, 1'b0};
    rd_en_c  = 1'b0;
    wr_en_c  = 1'b0;

    case (phase_q)
      PH_FETCH_LO: begin
        phase_d = PH_FETCH_HI;
        rd_en_c = 1'b1;
        if (ldpend_q) begin
          cy_d     = alu_res[8];
          ac_d     = alu_res[7:0];
          ldpend_d = 1'b0;
        end
      end

      PH_FETCH_HI: begin
        phase_d    = PH_DECODE;
        ir_d[7:0]  = mem_rd_data;
        addr_c     = {4'b0, pc_q, 1'b1};
        rd_en_c    = 1'b1;
      end

      PH_DECODE: begin
        phase_d    = PH_EXEC;
        ir_d[15:8] = mem_rd_data;
        pc_d       = pc_q + 11'd1;
      end

      default: begin
        phase_d = PH_FETCH_LO;
        addr_c  = effective_addr(ir_q[11:10], ir_q[7:0], x_q, y_q);
        if (is_load_op(op)) begin
          rd_en_c  = 1'b1;
          ldpend_d = 1'b1;
        end
        case (op)
          OP_ST:  wr_en_c = 1'b1;
          OP_LDI: ac_d = ir_q[7:0];
          OP_JI:  if (xint)  pc_d = ir_q[10:0];
          OP_JMP: pc_d = ir_q[10:0];
          OP_JC:  if (cy_q)  pc_d = ir_q[10:0];
          OP_JT:  if (xtick) pc_d = ir_q[10:0];
          OP_MISC: begin
            case (ir_q[3:0])
              MISC_TAX:  x_d = ac_q;
              MISC_TXA:  ac_d = x_q;
              MISC_TAYL: y_d[7:0] = ac_q;
              MISC_TAYH: y_d[15:8] = ac_q;
              MISC_CLC:  cy_d = 1'b0;
              MISC_SEC:  cy_d = 1'b1;
              MISC_RORC: begin
                ac_d = ror_res[8:1];
                cy_d = ror_res[0];
              end
`ifdef GLACIAL_UART_EN
              MISC_OUT:  uart_d = ac_q[0];
`else
              MISC_OUT:  ;
`endif
              MISC_INX:  x_d = x_q + 8'd1;
              default:   ;
            endcase
          end
          default: ;
        endcase
      end
    endcase
  end

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_FETCH_LO;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      ac_q     <= 8'h00;
      cy_q     <= 1'b0;
      x_q      <= 8'h00;
      y_q      <= 16'h0000;
      ldpend_q <= 1'b0;
`ifdef GLACIAL_UART_EN
      uart_q   <= 1'b1;
`endif
    end else begin
      phase_q  <= phase_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ac_q     <= ac_d;
      cy_q     <= cy_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ldpend_q <= ldpend_d;
`ifdef GLACIAL_UART_EN
      uart_q   <= uart_d;
`endif
    end
  end

  // Strobes are masked by reset so an aborted store never reaches the SRAM.
  assign mem_addr    = addr_c;
  assign mem_rd_en   = rd_en_c & ~reset;
  assign mem_wr_en   = wr_en_c & ~reset;
  assign mem_wr_data = ac_q;

`ifdef GLACIAL_UART_EN
  assign uart_tx = uart_q;
`else
  assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_glacial_core.sv
// tb_glacial_core: table-driven microprogram vectors for glacial_core plus
// hand-timed sequences for reset, fetch timing and mid-instruction abort.
// Each vector program is followed by a common epilogue that dumps ac,
// cy (as bit 7) and x into SRAM bytes 0x40..0x42.
module tb_glacial_core;

  localparam logic [15:0] NOP = 16'hC000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [7:0]  mem_wr_data;
  logic        xint = 1'b0;
  logic        xtick = 1'b0;
  logic        uart_tx;

  always #5 clk = ~clk;

  glacial_core #(.RESET_PC(11'h080)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .xint        (xint),
    .xtick       (xtick),
    .uart_tx     (uart_tx)
  );

  // SRAM model with a back-door loader used only while the core is in reset.
  logic [7:0]  mem [0:65535];
  logic        ld_en = 1'b0;
  logic [15:0] ld_addr = 16'h0;
  logic [7:0]  ld_data = 8'h0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
  end

  // Bus monitor: cycle index since reset release, protocol violations.
  int cyc = 0;
  int bad_cnt = 0;
  int cnt_1237 = 0;
  int cnt_st28 = 0;

  always @(negedge clk) begin
    if (reset) begin
      cyc <= 0;
      bad_cnt <= bad_cnt + int'(mem_rd_en || mem_wr_en);
    end else begin
      cyc <= cyc + 1;
      bad_cnt <= bad_cnt + int'(mem_rd_en && mem_wr_en)
                         + int'(mem_wr_en && (cyc % 4 != 3))
                         + int'((cyc % 4 == 2) && (mem_rd_en || mem_wr_en));
      cnt_1237 <= cnt_1237 + int'(mem_rd_en && mem_addr == 16'h1237 && (cyc % 4 == 3));
      cnt_st28 <= cnt_st28 + int'(mem_wr_en && mem_addr == 16'h0028 && mem_wr_data == 8'h5A);
    end
  end

  typedef struct packed {
    logic [7:0][15:0] prog;
    logic             xint;
    logic             xtick;
    logic [7:0]       exp_ac;
    logic             exp_cy;
    logic [7:0]       exp_x;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i,
                         input logic [15:0] p0, input logic [15:0] p1,
                         input logic [15:0] p2, input logic [15:0] p3,
                         input logic [15:0] p4, input logic [15:0] p5,
                         input logic [15:0] p6,
                         input logic xi, input logic xt,
                         input logic [7:0] eac, input logic ecy, input logic [7:0] ex);
    vecs[i].prog[0] = p0; vecs[i].prog[1] = p1; vecs[i].prog[2] = p2;
    vecs[i].prog[3] = p3; vecs[i].prog[4] = p4; vecs[i].prog[5] = p5;
    vecs[i].prog[6] = p6; vecs[i].prog[7] = NOP;
    vecs[i].xint = xi; vecs[i].xtick = xt;
    vecs[i].exp_ac = eac; vecs[i].exp_cy = ecy; vecs[i].exp_x = ex;
  endtask

  task automatic ldb(input logic [15:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic ldw(input logic [15:0] a, input logic [15:0] w);
    ldb(a, w[7:0]);
    ldb(a + 16'd1, w[15:8]);
  endtask

  // Assert reset, load program + trap + epilogue + data, release reset.
  task automatic start_run(input logic [7:0][15:0] prog, input logic xi, input logic xt);
    @(posedge clk); #1;
    reset = 1'b1; xint = xi; xtick = xt;
    for (int k = 0; k < 8; k++) ldw(16'h0100 + 16'(2 * k), prog[k]);
    // Epilogue at word 0x088: ST 40; LDI 0; RORC; ST 41; TXA; ST 42; JMP self
    ldw(16'h0110, 16'h1040); ldw(16'h0112, 16'h6000); ldw(16'h0114, 16'hB006);
    ldw(16'h0116, 16'h1041); ldw(16'h0118, 16'hB001); ldw(16'h011A, 16'h1042);
    ldw(16'h011C, 16'h808E);
    // Jump target at word 0x0A0: LDI 77; JMP epilogue
    ldw(16'h0140, 16'h6077); ldw(16'h0142, 16'h8088);
    ldb(16'h0030, 8'h01); ldb(16'h0031, 8'h0F); ldb(16'h0032, 8'hF0);
    ldb(16'h1237, 8'hC3); ldb(16'h0028, 8'h00);
    ldb(16'h0040, 8'hEE); ldb(16'h0041, 8'hEE); ldb(16'h0042, 8'hEE);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic stop_run(input string name, input logic [7:0] eac,
                          input logic ecy, input logic [7:0] ex);
    reset = 1'b1;
    @(posedge clk); #1;
    check({name, " ac"}, {8'h00, mem[16'h0040]}, {8'h00, eac});
    check({name, " cy"}, {8'h00, mem[16'h0041]}, {8'h00, ecy, 7'b0});
    check({name, " x"},  {8'h00, mem[16'h0042]}, {8'h00, ex});
  endtask

  logic [7:0][15:0] hp;
  int snap;
  logic exp_uart_low;

  initial begin
    //        program words                                               xint xtick  ac   cy  x
    set_vec(0,  16'h605A, 16'h1028, NOP, NOP, NOP, NOP, NOP,                   0, 0, 8'h5A, 0, 8'h00);
    set_vec(1,  16'hB005, 16'h60FF, 16'h2030, NOP, NOP, NOP, NOP,              0, 0, 8'h01, 1, 8'h00);
    set_vec(2,  16'h6034, 16'hB002, 16'h6012, 16'hB003, 16'h6003, 16'hB000, 16'h0C00,
                                                                               0, 0, 8'hC3, 0, 8'h03);
    set_vec(3,  16'h603C, 16'h3031, 16'h4032, 16'h5031, NOP, NOP, NOP,         0, 0, 8'hF3, 0, 8'h00);
    set_vec(4,  16'h6031, 16'hB000, 16'h04FF, NOP, NOP, NOP, NOP,              0, 0, 8'h01, 0, 8'h31);
    set_vec(5,  16'h60FF, 16'hB000, 16'hB008, NOP, NOP, NOP, NOP,              0, 0, 8'hFF, 0, 8'h00);
    set_vec(6,  16'h6000, 16'hB003, 16'h6030, 16'hB002, 16'h0802, NOP, NOP,    0, 0, 8'hF0, 0, 8'h00);
    set_vec(7,  16'hB005, 16'h6002, 16'hB006, NOP, NOP, NOP, NOP,              0, 0, 8'h81, 0, 8'h00);
    set_vec(8,  16'hB004, 16'h6003, 16'hB006, NOP, NOP, NOP, NOP,              0, 0, 8'h01, 1, 8'h00);
    set_vec(9,  16'hB005, 16'hB004, 16'h6010, 16'h2031, NOP, NOP, NOP,         0, 0, 8'h1F, 0, 8'h00);
    set_vec(10, 16'h6011, 16'h90A0, NOP, NOP, NOP, NOP, NOP,                   0, 0, 8'h11, 0, 8'h00);
    set_vec(11, 16'hB005, 16'h6011, 16'h90A0, NOP, NOP, NOP, NOP,              0, 0, 8'h77, 1, 8'h00);
    set_vec(12, 16'h6011, 16'hA0A0, NOP, NOP, NOP, NOP, NOP,                   0, 1, 8'h77, 0, 8'h00);
    set_vec(13, 16'h6011, 16'hA0A0, NOP, NOP, NOP, NOP, NOP,                   0, 0, 8'h11, 0, 8'h00);
    set_vec(14, 16'h6011, 16'h70A0, NOP, NOP, NOP, NOP, NOP,                   1, 0, 8'h77, 0, 8'h00);
    set_vec(15, 16'h6011, 16'h70A0, NOP, NOP, NOP, NOP, NOP,                   0, 1, 8'h11, 0, 8'h00);
    set_vec(16, 16'h6011, 16'h80A0, NOP, NOP, NOP, NOP, NOP,                   0, 0, 8'h77, 0, 8'h00);
    set_vec(17, 16'h6042, 16'hD000, 16'hB00F, 16'hF0FF, NOP, NOP, NOP,         0, 0, 8'h42, 0, 8'h00);
    set_vec(18, 16'hB005, 16'h600F, 16'h3032, NOP, NOP, NOP, NOP,              0, 0, 8'h00, 1, 8'h00);
    set_vec(19, 16'h6007, 16'hB000, 16'h6000, 16'hB001, NOP, NOP, NOP,         0, 0, 8'h07, 0, 8'h07);
    set_vec(20, 16'h6001, 16'h2030, 16'h2030, NOP, NOP, NOP, NOP,              0, 0, 8'h03, 0, 8'h00);

    // Reset state and first fetch timing, then the store vector.
    snap = cnt_st28;
    @(posedge clk); #1;
    @(negedge clk);
    check("reset rd_en", {15'b0, mem_rd_en}, 16'h0000);
    check("reset wr_en", {15'b0, mem_wr_en}, 16'h0000);
    check("reset uart_tx", {15'b0, uart_tx}, 16'h0001);
    start_run(vecs[0].prog, 1'b0, 1'b0);
    @(negedge clk);
    check("phase0 addr", mem_addr, 16'h0100);
    check("phase0 rd_en", {15'b0, mem_rd_en}, 16'h0001);
    check("phase0 uart_tx", {15'b0, uart_tx}, 16'h0001);
    @(negedge clk);
    check("phase1 addr", mem_addr, 16'h0101);
    check("phase1 rd_en", {15'b0, mem_rd_en}, 16'h0001);
    @(negedge clk);
    check("phase2 rd_en", {15'b0, mem_rd_en}, 16'h0000);
    repeat (120) @(posedge clk);
    #1;
    stop_run("st vec", 8'h5A, 1'b0, 8'h00);
    check("st sram 0x28", {8'h00, mem[16'h0028]}, 16'h005A);
    check("st wr cycles", 16'(cnt_st28 - snap), 16'd1);

    // Table of microprogram vectors.
    snap = cnt_1237;
    for (int i = 0; i < NV; i++) begin
      start_run(vecs[i].prog, vecs[i].xint, vecs[i].xtick);
      repeat (120) @(posedge clk);
      #1;
      stop_run($sformatf("vec%0d", i), vecs[i].exp_ac, vecs[i].exp_cy, vecs[i].exp_x);
    end
    check("mode11 addr 1237 in exec", 16'(cnt_1237 - snap), 16'd1);

    // OUT, then reset during execute of a store.
`ifdef GLACIAL_UART_EN
    exp_uart_low = 1'b1;
`else
    exp_uart_low = 1'b0;
`endif
    hp = '{default: NOP};
    hp[0] = 16'h6000; hp[1] = 16'hB007; hp[2] = 16'h605A; hp[3] = 16'h1028;
    start_run(hp, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    check("out uart_tx", {15'b0, uart_tx}, {15'b0, ~exp_uart_low});
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort st wr_en", {15'b0, mem_wr_en}, 16'h0000);
    @(posedge clk); #1;
    check("abort st sram 0x28", {8'h00, mem[16'h0028]}, 16'h0000);
    check("abort uart_tx", {15'b0, uart_tx}, 16'h0001);

    // Reset while a load is pending: the result must be discarded.
    hp = '{default: NOP};
    hp[0] = 16'h605A; hp[1] = 16'h0030;
    start_run(hp, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    hp = '{default: NOP};
    hp[0] = 16'h1040; hp[1] = 16'h8081;
    start_run(hp, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("pending load discarded", {8'h00, mem[16'h0040]}, 16'h0000);

    check("bus protocol violations", 16'(bad_cnt), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
